mul_share_arbiter: RTL

Round-robin controller that time-shares one pipelined 16x16 unsigned multiplier (`wallace_multiplier_16bit`, fixed latency, no stall) among `NUM_REQ` requesters. It sits between the requesters and the multiplier instance. It does three things:
- Grants at most one operand pair per cycle.
- Tracks each issued operation's requester ID through a delay line matched to the multiplier latency.
- Buffers finished products in a response FIFO with valid/ready backpressure. Credit-based issue keeps the no-stall pipeline from ever overflowing the FIFO.

---
 rtl/mul_share_arbiter_if.sv | 30 +++
 rtl/mul_share_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_if.sv
// Requester, multiplier and response signals of mul_share_arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface mul_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [15:0]           mul_a;
  logic [15:0]           mul_b;
  logic [31:0]           mul_result;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [31:0]           resp_product;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, resp_ready,
    output req_ready, mul_a, mul_b, resp_valid, resp_id, resp_product, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_result, resp_ready,
    input  req_ready, mul_a, mul_b, resp_valid, resp_id, resp_product, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency multiplier among NUM_REQ requesters,
// with an ID delay line and a credit-protected show-ahead response FIFO.
module mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input logic                clk,
  input logic                rst,
  mul_share_arbiter_if.slave bus
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int NSTG = MUL_LATENCY + 1;

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_idx;
  logic               grant_found;
  logic               credit_ok;
  logic               hs;
  logic [NUM_REQ-1:0] grant_vec;
  logic [15:0]        mul_a_q, mul_a_d;
  logic [15:0]        mul_b_q, mul_b_d;
  logic [NSTG-1:0]    vld_q;
  logic [IDW-1:0]     id_q [NSTG];
  logic [IDW+31:0]    fifo_mem [FIFO_DEPTH];
  logic [IDW+31:0]    head;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               push, pop;
  int                 inflight;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[IDW-1:0];
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[wrap_add(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Every op in the delay line already owns a FIFO slot, so the no-stall pipe never overflows it.
  always_comb begin
    inflight = 0;
    for (int s = 0; s < NSTG; s++) begin
      if (vld_q[s]) inflight = inflight + 1;
    end
  end

  assign credit_ok = (inflight + int'(count_q)) < FIFO_DEPTH;
  assign hs        = rst && grant_found && credit_ok;

  always_comb begin
    grant_vec = '0;
    if (hs) grant_vec[grant_idx] = 1'b1;
  end

  assign bus.req_ready = grant_vec;

  always_comb begin
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (hs) begin
      ptr_d   = wrap_add(grant_idx, 1);
      mul_a_d = bus.req_a[int'(grant_idx)*16 +: 16];
      mul_b_d = bus.req_b[int'(grant_idx)*16 +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;

  // The last stage lines up with mul_result for the op it tags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int s = 0; s < NSTG; s++) id_q[s] <= '0;
    end else begin
      vld_q[0] <= hs;
      id_q[0]  <= grant_idx;
      for (int s = 1; s < NSTG; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end

  assign push = vld_q[NSTG-1];
  assign pop  = (count_q != '0) && bus.resp_ready;

  always_ff @(posedge clk) begin
    if (rst && push) fifo_mem[wr_ptr_q] <= {id_q[NSTG-1], bus.mul_result};
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Head is masked so an empty FIFO presents zeros rather than stale contents.
  assign head             = fifo_mem[rd_ptr_q];
  assign bus.resp_valid   = (count_q != '0);
  assign bus.resp_id      = bus.resp_valid ? head[IDW+31:32] : '0;
  assign bus.resp_product = bus.resp_valid ? head[31:0] : '0;
  assign bus.busy         = (|vld_q) || (count_q != '0);
endmodule
